pulse_onehot_decoder: RTL

//   Registered, parametrised binary-to-one-hot decoder; successor to the

---
 rtl/pulse_onehot_decoder_if.sv | 32 +++
 rtl/pulse_onehot_decoder.sv | 90 +++++++++
 2 files changed

// File: rtl/pulse_onehot_decoder_if.sv
// Request/response bundle for the registered one-hot strobe decoder.
// The controller side is the master; the decoder is the slave.
interface pulse_onehot_decoder_if #(
    parameter int SEL_W = 2
);
    localparam int N = 1 << SEL_W;

    logic [SEL_W-1:0] sel;
    logic             req_valid;
    logic             req_ready;
    logic [N-1:0]     dec_out;
    logic             busy;
    logic             done;

    modport master (
        output sel,
        output req_valid,
        input  req_ready,
        input  dec_out,
        input  busy,
        input  done
    );

    modport slave (
        input  sel,
        input  req_valid,
        output req_ready,
        output dec_out,
        output busy,
        output done
    );
endinterface

// File: rtl/pulse_onehot_decoder.sv
// Registered binary-to-one-hot decoder driving either a held level or a
// fixed-length pulse on the selected output; en acts as a live global kill.
module pulse_onehot_decoder #(
    parameter int SEL_W      = 2,
    parameter int PULSE_LEN  = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    pulse_onehot_decoder_if.slave bus
);
    localparam int N = 1 << SEL_W;
    localparam bit LEVEL = (PULSE_LEN == 0);
    localparam logic [7:0] CNT_INIT =
        LEVEL ? 8'd0 : 8'(PULSE_LEN - 1);
    localparam logic [N-1:0] IDLE_V =
        ACTIVE_LOW ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t       state;
    logic [7:0]   cnt;
    logic [N-1:0] dec_q;
    logic         busy_q;
    logic         done_q;
    logic         accept;
    logic [N-1:0] onehot;
    logic [N-1:0] hot_v;

    assign bus.req_ready = en & (state == IDLE);
    assign accept        = bus.req_valid & bus.req_ready;
    assign onehot        = {{(N-1){1'b0}}, 1'b1} << bus.sel;
    assign hot_v         = ACTIVE_LOW ? ~onehot : onehot;

    assign bus.dec_out = dec_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            dec_q  <= IDLE_V;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A dropped enable wins over everything, including terminal count
            if (!en) begin
                state  <= IDLE;
                cnt    <= '0;
                dec_q  <= IDLE_V;
                busy_q <= 1'b0;
            end else if (LEVEL) begin
                if (accept) dec_q <= hot_v;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (accept) begin
                            dec_q  <= hot_v;
                            busy_q <= 1'b1;
                            cnt    <= CNT_INIT;
                            state  <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end else begin
                            dec_q  <= IDLE_V;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    a_onehot0: assert property (
        @(posedge clk) disable iff (rst)
        $onehot0(ACTIVE_LOW ? ~dec_q : dec_q)
    );
endmodule
